// File: rtl/copr_latency_engine_if.sv
// Request/result handshake bundle between the coprocessor reservation station and the latency engine.
// The engine connects to the slave side; the reservation station (or a bench) drives the master side.
interface copr_latency_engine_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TAG_WIDTH  = 6
);
    logic                  valid_i;
    logic                  ready_o;
    logic                  ctl_i;
    logic [TAG_WIDTH-1:0]  tag_i;
    logic [DATA_WIDTH-1:0] rs1_i;
    logic [DATA_WIDTH-1:0] rs2_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [TAG_WIDTH-1:0]  tag_o;
    logic [DATA_WIDTH-1:0] rd_o;

    modport master (
        output valid_i, ctl_i, tag_i, rs1_i, rs2_i, ready_i,
        input  ready_o, valid_o, tag_o, rd_o
    );

    modport slave (
        input  valid_i, ctl_i, tag_i, rs1_i, rs2_i, ready_i,
        output ready_o, valid_o, tag_o, rd_o
    );
endinterface

// File: rtl/copr_latency_engine.sv
// Tagged dummy coprocessor: a stallable add pipeline (ctl_i=0) and an iterative XOR unit whose
// latency comes from rs2[7:0] (ctl_i=1). The two modes never hold results at the same time.
module copr_latency_engine #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned TAG_WIDTH   = 6,
    parameter int unsigned PIPE_DEPTH  = 4,
    parameter int unsigned MAX_LATENCY = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    copr_latency_engine_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(MAX_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [CNT_W-1:0]      lat;
    logic [7:0]            lat_raw;

    logic [PIPE_DEPTH-1:0] stg_valid;
    logic [PIPE_DEPTH-1:0] take;
    logic [TAG_WIDTH-1:0]  stg_tag  [PIPE_DEPTH];
    logic [DATA_WIDTH-1:0] stg_data [PIPE_DEPTH];

    logic [TAG_WIDTH-1:0]  it_tag;
    logic [DATA_WIDTH-1:0] it_data;

    logic                  pipe_empty;
    logic                  acc_pipe;
    logic                  acc_iter;
    logic [DATA_WIDTH-1:0] sum;

    // take[i]: stage i may load this edge. A stage moves when any stage at or after it is
    // empty (bubbles collapse) or the output is being consumed; written without a ripple chain.
    always_comb begin
        take = '0;
        for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            take[i] = bus.ready_i;
            for (int unsigned j = i; j < PIPE_DEPTH; j++) begin
                if (!stg_valid[j]) begin
                    take[i] = 1'b1;
                end
            end
        end
    end

    assign pipe_empty  = ~|stg_valid;
    assign bus.ready_o = (state == IDLE) && (bus.ctl_i ? pipe_empty : take[0]);
    assign acc_pipe    = bus.valid_i && bus.ready_o && !flush_i && !bus.ctl_i;
    assign acc_iter    = bus.valid_i && bus.ready_o && !flush_i &&  bus.ctl_i;
    assign sum         = bus.rs1_i + bus.rs2_i;

    always_comb begin
        lat_raw = bus.rs2_i[7:0];
        if (lat_raw == 8'd0) begin
            lat = CNT_W'(1);
        end else if (32'(lat_raw) > MAX_LATENCY) begin
            lat = CNT_W'(MAX_LATENCY);
        end else begin
            lat = CNT_W'(lat_raw);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stg_valid <= '0;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                stg_tag[i]  <= '0;
                stg_data[i] <= '0;
            end
        end else begin
            if (take[0]) begin
                stg_valid[0] <= acc_pipe;
                if (acc_pipe) begin
                    stg_tag[0]  <= bus.tag_i;
                    stg_data[0] <= sum;
                end
            end
            for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
                if (take[i]) begin
                    stg_valid[i] <= stg_valid[i-1];
                    if (stg_valid[i-1]) begin
                        stg_tag[i]  <= stg_tag[i-1];
                        stg_data[i] <= stg_data[i-1];
                    end
                end
            end
            if (flush_i) begin
                stg_valid <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (acc_iter) begin
                    cnt_nxt   = lat - CNT_W'(1);
                    state_nxt = (lat == CNT_W'(1)) ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (flush_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            it_tag  <= '0;
            it_data <= '0;
        end else if (acc_iter) begin
            it_tag  <= bus.tag_i;
            it_data <= bus.rs1_i ^ bus.rs2_i;
        end
    end

    always_comb begin
        if (state == DONE) begin
            bus.valid_o = 1'b1;
            bus.tag_o   = it_tag;
            bus.rd_o    = it_data;
        end else begin
            bus.valid_o = stg_valid[PIPE_DEPTH-1];
            bus.tag_o   = stg_tag[PIPE_DEPTH-1];
            bus.rd_o    = stg_data[PIPE_DEPTH-1];
        end
    end
endmodule

// File: tb/tb_copr_latency_engine.sv
// Bench for copr_latency_engine: directed scenarios followed by random traffic, all checked every
// cycle against a queue-based reference model of in-flight requests.
module tb_copr_latency_engine;
    localparam int DW = 64;
    localparam int TW = 6;
    localparam int PD = 4;
    localparam int ML = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    copr_latency_engine_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) b ();

    copr_latency_engine #(
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW),
        .PIPE_DEPTH (PD),
        .MAX_LATENCY(ML)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .flush_i(flush),
        .bus    (b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             a;
        logic [TW-1:0]  tag;
        logic [DW-1:0]  data;
    } item_t;

    // Model: pipeline requests in accept order with their accept edge; an iterative request with
    // the edge from which its result is visible. t counts rising edges since reset release.
    item_t          q[$];
    int             t;
    bit             it_pend;
    int             it_done;
    logic [TW-1:0]  it_tag;
    logic [DW-1:0]  it_data;
    int             n_cmp;
    int             n_bad;

    task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic int ref_lat(input logic [DW-1:0] rs2);
        logic [7:0] lo;
        int         l;
        lo = rs2[7:0];
        l  = int'(lo);
        if (l == 0) return 1;
        if (l > ML) return ML;
        return l;
    endfunction

    // An item sits PD-1 stages deep at most, at most one behind its predecessor, and never
    // further than its age. Returns whether stage 0 is unoccupied after the next edge.
    function automatic bit stage0_clear(input int skip);
        int p;
        int pk;
        p = 1 << 30;
        for (int k = skip; k < q.size(); k++) begin
            pk = (t + 1) - q[k].a;
            if (k == skip) begin
                if (pk > PD - 1) pk = PD - 1;
            end else if (pk > p - 1) begin
                pk = p - 1;
            end
            p = pk;
        end
        return p >= 1;
    endfunction

    task automatic drive(input bit v, input bit ctl, input int tag, input logic [DW-1:0] rs1,
                         input logic [DW-1:0] rs2, input bit rdy, input bit fl);
        b.valid_i = v;
        b.ctl_i   = ctl;
        b.tag_i   = TW'(tag);
        b.rs1_i   = rs1;
        b.rs2_i   = rs2;
        b.ready_i = rdy;
        flush     = fl;
    endtask

    task automatic tick(input string lbl, output bit acc);
        bit             it_v;
        bit             pipe_v;
        bit             exp_v;
        bit             exp_r;
        bit             ret;
        logic [TW-1:0]  et;
        logic [DW-1:0]  ed;
        @(negedge clk);
        it_v   = it_pend && (t >= it_done);
        pipe_v = (q.size() > 0) && ((t - q[0].a) >= PD - 1);
        exp_v  = it_v || pipe_v;
        et     = '0;
        ed     = '0;
        if (it_v) begin
            et = it_tag;
            ed = it_data;
        end else if (pipe_v) begin
            et = q[0].tag;
            ed = q[0].data;
        end
        ret = exp_v && b.ready_i;
        if (it_pend)        exp_r = 1'b0;
        else if (b.ctl_i)   exp_r = (q.size() == 0);
        else                exp_r = stage0_clear((ret && pipe_v) ? 1 : 0);
        check({lbl, ".ready"}, DW'(b.ready_o), DW'(exp_r));
        check({lbl, ".valid"}, DW'(b.valid_o), DW'(exp_v));
        if (exp_v) begin
            check({lbl, ".tag"}, DW'(b.tag_o), DW'(et));
            check({lbl, ".rd"}, b.rd_o, ed);
        end
        acc = b.valid_i && exp_r && !flush;
        if (flush) begin
            q.delete();
            it_pend = 1'b0;
        end else begin
            if (ret) begin
                if (it_v) it_pend = 1'b0;
                else      void'(q.pop_front());
            end
            if (acc) begin
                if (b.ctl_i) begin
                    it_pend = 1'b1;
                    it_done = t + ref_lat(b.rs2_i);
                    it_tag  = b.tag_i;
                    it_data = b.rs1_i ^ b.rs2_i;
                end else begin
                    q.push_back('{a: t + 1, tag: b.tag_i, data: b.rs1_i + b.rs2_i});
                end
            end
        end
        @(posedge clk);
        t++;
        #1;
    endtask

    task automatic idle(input string lbl, input int n, input bit rdy);
        bit acc;
        drive(1'b0, 1'b0, 0, '0, '0, rdy, 1'b0);
        for (int i = 0; i < n; i++) tick(lbl, acc);
    endtask

    task automatic issue(input string lbl, input bit ctl, input int tag, input logic [DW-1:0] rs1,
                         input logic [DW-1:0] rs2, input bit rdy);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 64 && !acc; i++) begin
            drive(1'b1, ctl, tag, rs1, rs2, rdy, 1'b0);
            tick(lbl, acc);
        end
        check({lbl, ".accepted"}, DW'(acc), DW'(1));
        drive(1'b0, 1'b0, 0, '0, '0, rdy, 1'b0);
    endtask

    task automatic drain(input string lbl);
        bit acc;
        drive(1'b0, 1'b0, 0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 200 && (q.size() != 0 || it_pend); i++) tick(lbl, acc);
        tick(lbl, acc);
    endtask

    // Counts cycles from the accept edge until the result shows, then checks value and latency.
    task automatic iter_case(input string lbl, input int tag, input logic [DW-1:0] rs1,
                             input logic [DW-1:0] rs2, input int exp_lat, input logic [DW-1:0] exp_rd);
        bit acc;
        int n;
        issue(lbl, 1'b1, tag, rs1, rs2, 1'b1);
        n = 1;
        while (!b.valid_o && n < 64) begin
            tick(lbl, acc);
            n++;
        end
        check({lbl, ".latency"}, DW'(n), DW'(exp_lat));
        check({lbl, ".result"}, b.rd_o, exp_rd);
        drain(lbl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit             acc;
        bit             v;
        bit             ctl;
        bit             rdy;
        bit             fl;
        logic [DW-1:0]  r1;
        logic [DW-1:0]  r2;
        n_cmp   = 0;
        n_bad   = 0;
        t       = 0;
        it_pend = 1'b0;
        it_done = 0;
        it_tag  = '0;
        it_data = '0;

        drive(1'b0, 1'b0, 0, '0, '0, 1'b1, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.valid", DW'(b.valid_o), DW'(0));
        check("reset.tag", DW'(b.tag_o), DW'(0));
        check("reset.rd", b.rd_o, DW'(0));
        check("reset.ready", DW'(b.ready_o), DW'(1));
        rst_n = 1'b1;
        idle("idle", 2, 1'b1);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, i, DW'(i), DW'(100), 1'b1, 1'b0);
            tick("burst", acc);
        end
        drain("burst");

        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8 + i, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
            tick("bp.fill", acc);
        end
        check("bp.full_ready", DW'(b.ready_o), DW'(0));
        idle("bp.hold", 3, 1'b0);
        drive(1'b1, 1'b0, 20, DW'(7), DW'(9), 1'b1, 1'b0);
        #1;
        check("bp.advance_through", DW'(b.ready_o), DW'(1));
        tick("bp.release", acc);
        drain("bp.release");

        iter_case("iter5", 1, DW'(64'hFF), DW'(5), 5, DW'(64'hFA));
        iter_case("iter0", 2, DW'(64'h12), DW'(0), 1, DW'(64'h12));
        iter_case("iter200", 3, DW'(64'h3), DW'(200), 32, DW'(64'hCB));
        iter_case("iter256", 4, DW'(64'h0), DW'(64'h100), 1, DW'(64'h100));

        issue("mx.pipe", 1'b0, 5, DW'(1), DW'(2), 1'b1);
        drive(1'b1, 1'b1, 6, DW'(3), DW'(4), 1'b1, 1'b0);
        #1;
        check("mx.iter_blocked", DW'(b.ready_o), DW'(0));
        issue("mx.iter", 1'b1, 6, DW'(3), DW'(10), 1'b1);
        drive(1'b1, 1'b0, 7, DW'(5), DW'(6), 1'b1, 1'b0);
        #1;
        check("mx.pipe_blocked", DW'(b.ready_o), DW'(0));
        issue("mx.pipe2", 1'b0, 7, DW'(5), DW'(6), 1'b1);
        drain("mx");

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 30 + i, DW'(i), DW'(1), 1'b1, 1'b0);
            tick("fl.pipe", acc);
        end
        drive(1'b1, 1'b0, 40, DW'(9), DW'(9), 1'b1, 1'b1);
        tick("fl.pipe", acc);
        check("fl.pipe_valid", DW'(b.valid_o), DW'(0));
        check("fl.pipe_ready", DW'(b.ready_o), DW'(1));
        idle("fl.pipe_after", 8, 1'b1);

        issue("fl.busy", 1'b1, 41, DW'(1), DW'(20), 1'b1);
        idle("fl.busy", 3, 1'b1);
        drive(1'b0, 1'b0, 0, '0, '0, 1'b1, 1'b1);
        tick("fl.busy", acc);
        check("fl.busy_valid", DW'(b.valid_o), DW'(0));
        check("fl.busy_ready", DW'(b.ready_o), DW'(1));
        idle("fl.busy_after", 25, 1'b1);

        issue("fl.retire", 1'b0, 42, DW'(4), DW'(4), 1'b0);
        idle("fl.retire", 4, 1'b0);
        drive(1'b0, 1'b0, 0, '0, '0, 1'b1, 1'b1);
        tick("fl.retire", acc);
        idle("fl.retire_after", 6, 1'b1);

        issue("ar.iter", 1'b1, 43, DW'(64'hAB), DW'(3), 1'b0);
        idle("ar.done", 5, 1'b0);
        check("ar.done_valid", DW'(b.valid_o), DW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.valid", DW'(b.valid_o), DW'(0));
        check("ar.tag", DW'(b.tag_o), DW'(0));
        check("ar.rd", b.rd_o, DW'(0));
        q.delete();
        it_pend = 1'b0;
        @(posedge clk);
        t++;
        #1;
        rst_n = 1'b1;
        check("ar.ready", DW'(b.ready_o), DW'(1));
        idle("ar.after", 4, 1'b1);

        for (int n = 0; n < 600; n++) begin
            v   = ($urandom_range(0, 99) < 60);
            ctl = ($urandom_range(0, 99) < 25);
            rdy = ($urandom_range(0, 99) < 70);
            fl  = ($urandom_range(0, 99) < 3);
            r1  = {$urandom, $urandom};
            r2  = {$urandom, $urandom};
            r2[7:0] = 8'($urandom_range(0, 40));
            drive(v, ctl, int'($urandom_range(0, 63)), r1, r2, rdy, fl);
            tick("rnd", acc);
        end
        drain("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/copr_latency_engine.md
# copr_latency_engine

Tagged dummy coprocessor execution engine that sits directly downstream of the coprocessor reservation station. It consumes one operand pair per handshake and returns a tagged result through a valid/ready port. It has two modes: a fixed-depth stallable pipeline and an iterative multi-cycle unit with operand-programmed latency. The engine exercises the reservation station and CDB path under both back-to-back and long-latency traffic.

## Interface
Parameters:
- DATA_WIDTH, 64, operand/result width.
- TAG_WIDTH, 6, ROB tag width (matches rob_idx_t).
- PIPE_DEPTH, 4, pipeline-mode stages (>=1).
- MAX_LATENCY, 32, iterative-mode latency ceiling (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous flush; squashes all in-flight work.
- valid_i  in  1  request valid from the reservation station.
- ready_o  out  1  engine can accept the request (may depend combinationally on ctl_i).
- ctl_i  in  1  mode: 0 = pipeline, 1 = iterative.
- tag_i  in  TAG_WIDTH  destination ROB tag.
- rs1_i, rs2_i  in  DATA_WIDTH each  operands.
- valid_o  out  1  result valid.
- ready_i  in  1  reservation station accepts the result.
- tag_o  out  TAG_WIDTH  tag of the result.
- rd_o  out  DATA_WIDTH  result.

## Operation
- Pipeline mode:
  - rd = rs1 + rs2, modulo 2^DATA_WIDTH.
  - PIPE_DEPTH registered stages, each holding {valid, tag, data}.
  - A stage advances when the next stage is empty or is itself advancing. The last stage advances on ready_i.
  - Bubbles collapse under stall.
- Iterative mode:
  - rd = rs1 XOR rs2.
  - Latency L = rs2[7:0] clamped to [1, MAX_LATENCY]; rs2[7:0] = 0 gives L = 1.
  - Counter width is clog2(MAX_LATENCY+1).
- Iterative FSM:
  - IDLE: on accept with ctl_i=1, latch tag/result, load counter = L-1, go to BUSY. If L = 1, go straight to DONE.
  - BUSY: decrement each cycle; when counter = 1, go to DONE.
  - DONE: hold valid_o; on ready_i, return to IDLE.
- Mode exclusivity (results never compete for the output):
  - ready_o = FSM==IDLE AND (ctl_i=0 ? stage0 free-or-advancing : all pipeline stages empty).
- Output mux:
  - When FSM==DONE, the iterative result drives the output.
  - Otherwise the last pipeline stage drives it.
  - tag_o/rd_o are don't-care when valid_o=0 but must be stable while valid_o=1 and ready_i=0.
- Flush:
  - Clears all stage valids and the counter, and forces the FSM to IDLE on the next edge.
  - valid_i is ignored in the flush cycle (no accept).
  - valid_o may be high in the flush cycle. It is not required to complete.
- Reset:
  - Same clearing as flush, asynchronously.
  - After reset: valid_o=0, tag_o=0, rd_o=0, ready_o=1.

## Timing
- Handshakes:
  - Accept on valid_i & ready_o at a rising edge.
  - Retire on valid_o & ready_i.
- Pipeline latency: accept at edge t gives valid_o high after edge t+PIPE_DEPTH-1 (first cycle after that edge) when unstalled.
- Pipeline throughput: 1 request/cycle under continuous ready_i.
- Iterative: accept at edge t gives valid_o high L cycles after the accept cycle. ready_o stays 0 until the cycle after retirement.
- Full pipeline with ready_i=0:
  - ready_o=0.
  - On the cycle ready_i rises, ready_o=1 in the same cycle (advance-through).
- Mode switch from pipeline to iterative waits for pipeline drain. Iterative to pipeline waits for FSM IDLE.
- Simultaneous flush and retire: flush wins for state. The retire handshake counts downstream, with no duplicate after flush.

## Test plan
- Pipeline burst: 8 requests rs1=i, rs2=100, tags 0..7, ready_i=1 -> results 100..107 in tag order, first at PIPE_DEPTH cycles, then one per cycle.
- Backpressure: fill the pipeline with ready_i=0 -> ready_o=0 after 4 accepts, outputs stable. Release ready_i -> 4 results in order, no loss or duplication.
- Iterative latency: rs1=0xFF, rs2=5 -> rd_o=0xFA, valid_o exactly 5 cycles after accept. rs2=0 -> L=1. rs2=200 -> L=32.
- Mode exclusion: issue a pipeline op followed by an iterative op -> iterative ready_o=0 until the pipeline drains. Pipeline op during BUSY -> ready_o=0.
- Flush mid-operation: flush with 3 pipeline ops in flight, and separately during BUSY -> valid_o=0 next cycle, ready_o=1, no stale result emerges later.
- Async reset asserted during DONE with ready_i=0 -> valid_o drops immediately, all outputs 0, ready_o=1 after release.
